// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI memory-slave transaction sequencer.
// Optional watchdog in spi_fsm is enabled with the SPI_FSM_TIMEOUT_EN macro.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_GET_ADDR    = 3'd1,
        ST_DECIDE      = 3'd2,
        ST_READ_LOAD   = 3'd3,
        ST_READ_SHIFT  = 3'd4,
        ST_WRITE_RECV  = 3'd5,
        ST_WRITE_STORE = 3'd6,
        ST_DONE        = 3'd7
    } spi_state_t;

    localparam int DEF_ADDR_BITS      = 7;
    localparam int DEF_DATA_BITS      = 8;
    localparam int DEF_CNT_W          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/spi_fsm_if.sv
// Bundle of conditioned SPI inputs and datapath strobes around spi_fsm.
// master = conditioner/datapath side, slave = the sequencer itself.
interface spi_fsm_if;

    logic       cs_cond;
    logic       sclk_posedge;
    logic       sclk_negedge;
    logic       rw_bit;
    logic       addr_we;
    logic       dm_we;
    logic       sr_we;
    logic       miso_buff_en;
    logic       busy;
    logic [2:0] state_o;

    modport master (
        output cs_cond, sclk_posedge, sclk_negedge, rw_bit,
        input  addr_we, dm_we, sr_we, miso_buff_en, busy, state_o
    );

    modport slave (
        input  cs_cond, sclk_posedge, sclk_negedge, rw_bit,
        output addr_we, dm_we, sr_we, miso_buff_en, busy, state_o
    );

endinterface

// File: rtl/spi_bit_counter.sv
// Clearable bit counter with a terminal-count compare against a runtime limit.
module spi_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_at_limit
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_limit = (r_count == i_limit);

endmodule

// File: rtl/spi_fsm.sv
// SPI memory-slave transaction sequencer: registered strobes for address latch,
// data memory, shift-register load and MISO enable. Watchdog: SPI_FSM_TIMEOUT_EN.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic      clk,
    input  logic      reset,
    spi_fsm_if.slave  bus
);

    localparam logic [CNT_W-1:0] L_ADDR_LIM = CNT_W'(ADDR_BITS);
    localparam logic [CNT_W-1:0] L_DATA_LIM = CNT_W'(DATA_BITS - 1);

    spi_state_t       r_state;
    spi_state_t       w_next;
    logic             r_addr_we;
    logic             r_dm_we;
    logic             r_sr_we;
    logic             r_miso_en;
    logic             r_busy;
    logic             w_edge;
    logic [CNT_W-1:0] w_limit;
    logic             w_at_limit;
    logic             w_term;
    logic             w_abort;
    logic             w_timeout;
    logic             w_cnt_clr;

    // Each shifting state listens to exactly one edge type and its own limit.
    always_comb begin
        w_edge  = 1'b0;
        w_limit = L_DATA_LIM;
        case (r_state)
            ST_GET_ADDR: begin
                w_edge  = bus.sclk_posedge;
                w_limit = L_ADDR_LIM;
            end
            ST_WRITE_RECV: w_edge = bus.sclk_posedge;
            ST_READ_SHIFT: w_edge = bus.sclk_negedge;
            default:       w_edge = 1'b0;
        endcase
    end

    assign w_abort   = bus.cs_cond && (r_state != ST_IDLE);
    assign w_term    = w_edge && w_at_limit;
    assign w_cnt_clr = bus.cs_cond || (r_state == ST_IDLE) || w_term || w_timeout;

    spi_bit_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_cnt_clr),
        .i_en       (w_edge),
        .i_limit    (w_limit),
        .o_at_limit (w_at_limit)
    );

`ifdef SPI_FSM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;
    logic            w_watched;
    logic            w_any_edge;
    logic            w_wdog_clr;

    assign w_watched  = (r_state == ST_GET_ADDR) || (r_state == ST_READ_SHIFT) ||
                        (r_state == ST_WRITE_RECV);
    assign w_any_edge = bus.sclk_posedge || bus.sclk_negedge;
    // Any exit from a watched state goes through one of these terms, so the
    // count is always zero when a watched state is entered.
    assign w_wdog_clr = !w_watched || w_any_edge || bus.cs_cond || w_term || w_timeout;
    assign w_timeout  = w_watched && !w_any_edge &&
                        (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (w_wdog_clr) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    // Never true: without the watchdog a stalled master holds the FSM.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = ST_IDLE;
        end else if (w_timeout) begin
            w_next = ST_DONE;
        end else begin
            case (r_state)
                ST_IDLE:        if (!bus.cs_cond) w_next = ST_GET_ADDR;
                ST_GET_ADDR:    if (w_term) w_next = ST_DECIDE;
                ST_DECIDE:      w_next = bus.rw_bit ? ST_READ_LOAD : ST_WRITE_RECV;
                ST_READ_LOAD:   w_next = ST_READ_SHIFT;
                ST_READ_SHIFT:  if (w_term) w_next = ST_DONE;
                ST_WRITE_RECV:  if (w_term) w_next = ST_WRITE_STORE;
                ST_WRITE_STORE: w_next = ST_DONE;
                ST_DONE:        w_next = ST_DONE;
                default:        w_next = ST_IDLE;
            endcase
        end
    end

    // Strobes fire on specific transitions; an abort or timeout goes elsewhere,
    // so it can never produce one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_addr_we <= 1'b0;
            r_dm_we   <= 1'b0;
            r_sr_we   <= 1'b0;
            r_miso_en <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_addr_we <= (r_state == ST_GET_ADDR)    && (w_next == ST_DECIDE);
            r_dm_we   <= (r_state == ST_WRITE_STORE) && (w_next == ST_DONE);
            r_sr_we   <= (r_state == ST_READ_LOAD)   && (w_next == ST_READ_SHIFT);
            r_miso_en <= (w_next == ST_READ_SHIFT);
            r_busy    <= (w_next != ST_IDLE);
        end
    end

    assign bus.addr_we      = r_addr_we;
    assign bus.dm_we        = r_dm_we;
    assign bus.sr_we        = r_sr_we;
    assign bus.miso_buff_en = r_miso_en;
    assign bus.busy         = r_busy;
    assign bus.state_o      = r_state;

endmodule

// File: tb/tb_spi_fsm.sv
// Directed self-checking bench for spi_fsm; the timeout case runs only when
// SPI_FSM_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 16).
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spi_fsm_if bus ();

    spi_fsm #(
        .ADDR_BITS      (7),
        .DATA_BITS      (8),
        .CNT_W          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe activity counters, sampled mid-cycle.
    int n_addr     = 0;
    int n_dm       = 0;
    int n_sr       = 0;
    int n_miso     = 0;
    int n_miso_neg = 0;

    always @(negedge clk) begin
        if (bus.addr_we)      n_addr <= n_addr + 1;
        if (bus.dm_we)        n_dm   <= n_dm + 1;
        if (bus.sr_we)        n_sr   <= n_sr + 1;
        if (bus.miso_buff_en) n_miso <= n_miso + 1;
        if (bus.miso_buff_en && bus.sclk_negedge) n_miso_neg <= n_miso_neg + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic pos, input logic neg);
        bus.sclk_posedge = pos;
        bus.sclk_negedge = neg;
        tick();
        bus.sclk_posedge = 1'b0;
        bus.sclk_negedge = 1'b0;
    endtask

    // Eight address-phase posedges; returns right after the 8th is consumed.
    task automatic send_addr(input logic rw);
        bus.rw_bit = rw;
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0);
            tick();
        end
        pulse(1'b1, 1'b0);
    endtask

    task automatic write_frame(input string tag);
        int a0, d0, m0;
        a0 = n_addr; d0 = n_dm; m0 = n_miso;
        bus.cs_cond = 1'b0;
        tick();
        check({tag, "_getaddr_state"}, bus.state_o, 32'd1);
        check({tag, "_getaddr_busy"}, bus.busy, 32'd1);
        send_addr(1'b0);
        check({tag, "_addr_we"}, bus.addr_we, 32'd1);
        check({tag, "_decide_state"}, bus.state_o, 32'd2);
        tick();
        check({tag, "_addr_we_drop"}, bus.addr_we, 32'd0);
        check({tag, "_recv_state"}, bus.state_o, 32'd5);
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0);
            tick();
        end
        pulse(1'b1, 1'b0);
        check({tag, "_store_state"}, bus.state_o, 32'd6);
        check({tag, "_dm_we_n1"}, bus.dm_we, 32'd0);
        tick();
        check({tag, "_dm_we_n2"}, bus.dm_we, 32'd1);
        check({tag, "_done_state"}, bus.state_o, 32'd7);
        tick();
        check({tag, "_dm_we_n3"}, bus.dm_we, 32'd0);
        bus.cs_cond = 1'b1;
        tick();
        check({tag, "_idle_state"}, bus.state_o, 32'd0);
        check({tag, "_idle_busy"}, bus.busy, 32'd0);
        check({tag, "_addr_we_count"}, n_addr - a0, 32'd1);
        check({tag, "_dm_we_count"}, n_dm - d0, 32'd1);
        check({tag, "_miso_cycles"}, n_miso - m0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0, m0, a0, d0, k;

        reset            = 1'b1;
        bus.cs_cond      = 1'b1;
        bus.sclk_posedge = 1'b0;
        bus.sclk_negedge = 1'b0;
        bus.rw_bit       = 1'b0;
        tick();
        tick();
        check("rst_state", bus.state_o, 32'd0);
        check("rst_strobes", {bus.addr_we, bus.dm_we, bus.sr_we, bus.miso_buff_en}, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_state", bus.state_o, 32'd0);

        write_frame("wr1");

        // Read frame
        s0 = n_sr;
        bus.cs_cond = 1'b0;
        tick();
        send_addr(1'b1);
        check("rd_addr_we", bus.addr_we, 32'd1);
        tick();
        check("rd_load_state", bus.state_o, 32'd3);
        check("rd_sr_we_n2", bus.sr_we, 32'd0);
        tick();
        check("rd_sr_we_n3", bus.sr_we, 32'd1);
        check("rd_shift_state", bus.state_o, 32'd4);
        check("rd_miso_on", bus.miso_buff_en, 32'd1);
        m0 = n_miso_neg;
        for (int i = 0; i < 7; i++) begin
            pulse((i == 3), 1'b1);
            tick();
        end
        check("rd_shift_after7", bus.state_o, 32'd4);
        check("rd_miso_after7", bus.miso_buff_en, 32'd1);
        pulse(1'b0, 1'b1);
        check("rd_done_state", bus.state_o, 32'd7);
        check("rd_miso_off", bus.miso_buff_en, 32'd0);
        tick();
        check("rd_miso_negedges", n_miso_neg - m0, 32'd8);
        check("rd_sr_we_count", n_sr - s0, 32'd1);
        bus.cs_cond = 1'b1;
        tick();
        check("rd_idle_state", bus.state_o, 32'd0);

        // CS abort during address phase, with a coincident edge pulse
        a0 = n_addr;
        bus.cs_cond = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0);
            tick();
        end
        bus.cs_cond = 1'b1;
        pulse(1'b1, 1'b0);
        check("abort_state", bus.state_o, 32'd0);
        check("abort_counter", dut.u_cnt.r_count, 32'd0);
        check("abort_strobes", {bus.addr_we, bus.dm_we, bus.sr_we, bus.miso_buff_en}, 32'd0);
        tick();
        check("abort_addr_we_count", n_addr - a0, 32'd0);
        write_frame("wr2");

        // CS rises together with the 8th data posedge
        d0 = n_dm;
        bus.cs_cond = 1'b0;
        tick();
        send_addr(1'b0);
        tick();
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0);
            tick();
        end
        bus.cs_cond = 1'b1;
        pulse(1'b1, 1'b0);
        check("coinc_state", bus.state_o, 32'd0);
        check("coinc_dm_we", bus.dm_we, 32'd0);
        tick();
        tick();
        check("coinc_dm_we_count", n_dm - d0, 32'd0);

        // Asynchronous reset while shifting out read data
        bus.cs_cond = 1'b0;
        tick();
        send_addr(1'b1);
        tick();
        tick();
        pulse(1'b0, 1'b1);
        check("areset_pre_miso", bus.miso_buff_en, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_miso", bus.miso_buff_en, 32'd0);
        check("areset_state", bus.state_o, 32'd0);
        check("areset_busy", bus.busy, 32'd0);
        bus.cs_cond = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check("areset_idle", bus.state_o, 32'd0);

`ifdef SPI_FSM_TIMEOUT_EN
        // SCLK stops mid-address; watchdog limit is 16 cycles
        a0 = n_addr;
        bus.cs_cond = 1'b0;
        tick();
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b1, 1'b0);
        tick();
        pulse(1'b1, 1'b0);
        k = 0;
        while (bus.state_o != 3'd7 && k < 40) begin
            tick();
            k++;
        end
        check("wdog_cycles", k, 32'd16);
        check("wdog_state", bus.state_o, 32'd7);
        check("wdog_no_addr_we", n_addr - a0, 32'd0);
        bus.cs_cond = 1'b1;
        tick();
        check("wdog_idle", bus.state_o, 32'd0);
`else
        k = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_fsm.md
# spi_fsm

Transaction sequencer for the SPI memory slave. It consumes the already-conditioned chip-select and SCLK edge pulses produced by the input conditioners, and drives the one-cycle strobes that load the address latch, write data memory, parallel-load the shift register and enable the MISO tri-state buffer. It sits between the three input conditioners (CS, SCLK, MOSI) and the shift-register / address-latch / data-memory datapath.

## Interface
Parameters:
- ADDR_BITS, 7, address bits per frame; the R/W bit follows the address.
- DATA_BITS, 8, data bits per transfer.
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > max(ADDR_BITS+1, DATA_BITS).
- TIMEOUT_CYCLES, 255, idle-SCLK limit; used only with SPI_FSM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic is on its posedge.
- reset  in  1  asynchronous, active-high reset.
- cs_cond  in  1  conditioned chip select, active-low.
- sclk_posedge  in  1  one-clk pulse at a conditioned SCLK rising edge.
- sclk_negedge  in  1  one-clk pulse at a conditioned SCLK falling edge.
- rw_bit  in  1  shift-register bit 0, sampled in DECIDE; 1 = read, 0 = write.
- addr_we  out  1  address-latch write strobe.
- dm_we  out  1  data-memory write strobe.
- sr_we  out  1  shift-register parallel-load strobe.
- miso_buff_en  out  1  MISO tri-state enable.
- busy  out  1  high in every state except IDLE.
- state_o  out  3  current state encoding, for debug.

## Operation
- States: IDLE, GET_ADDR, DECIDE, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_STORE, DONE.
- IDLE: counter = 0. Transition to GET_ADDR when cs_cond = 0.
- GET_ADDR: counter increments on each sclk_posedge. When sclk_posedge arrives with counter = ADDR_BITS:
  - counter clears;
  - addr_we pulses for one cycle;
  - state moves to DECIDE.
- DECIDE: one cycle. rw_bit = 1 goes to READ_LOAD; otherwise goes to WRITE_RECV.
- READ_LOAD: one cycle, used as memory read latency. sr_we pulses in the cycle after entry, coincident with the move to READ_SHIFT.
- READ_SHIFT:
  - miso_buff_en = 1 throughout.
  - counter increments on each sclk_negedge.
  - When sclk_negedge arrives with counter = DATA_BITS-1: counter clears, go to DONE.
- WRITE_RECV: counter increments on each sclk_posedge. When sclk_posedge arrives with counter = DATA_BITS-1: counter clears, go to WRITE_STORE.
- WRITE_STORE: dm_we = 1 for exactly one cycle, then go to DONE.
- DONE: all strobes 0. Return to IDLE when cs_cond = 1.
- CS abort: cs_cond = 1 in any non-IDLE state takes priority over every other condition.
  - Next state is IDLE and counter clears.
  - No strobe is asserted in that cycle, even if an edge pulse coincides.
- Edge pulses that arrive in IDLE, DECIDE, READ_LOAD, WRITE_STORE or DONE are ignored.
- Simultaneous sclk_posedge and sclk_negedge are legal. Each state counts only its own edge type.
- Counter never exceeds DATA_BITS; no wrap-around occurs.

## Timing
- All outputs are registered Moore outputs decoded from state.
- Reset values: state IDLE, counter 0, addr_we 0, dm_we 0, sr_we 0, miso_buff_en 0, busy 0, state_o 0.
- Latency from the qualifying edge pulse (cycle N):
  - addr_we is high in cycle N+1.
  - Final write edge: dm_we is high in cycle N+2.
  - Last address edge on a read: sr_we is high in cycle N+3.
- Reset asserted mid-transaction clears all state immediately. Strobes drop asynchronously.

## Configuration
- SPI_FSM_TIMEOUT_EN defined:
  - A watchdog counts clk cycles since the last sclk edge pulse while in GET_ADDR, READ_SHIFT or WRITE_RECV.
  - When the count reaches TIMEOUT_CYCLES, the FSM forces DONE with no strobe.
  - The watchdog clears on every edge pulse and on every state change.
- SPI_FSM_TIMEOUT_EN undefined: no watchdog logic exists. A stalled master holds the FSM until cs_cond rises. TIMEOUT_CYCLES is ignored.

## Structure
- Shared package spi_pkg holds:
  - state enum spi_state_t, 3-bit encoding, IDLE = 0, values in the order listed above;
  - default ADDR_BITS and DATA_BITS constants.
- One sub-module, spi_bit_counter, contains:
  - clear and enable inputs;
  - a CNT_W-bit count;
  - a terminal-count compare against a runtime limit.
- The FSM instantiates spi_bit_counter once and selects the edge source and limit per state.

## Test plan
- Write frame: CS low, address 0x15 with rw_bit = 0, then data 0xA5 over 8 posedges → addr_we one pulse after the 8th address posedge; dm_we one pulse 2 cycles after the 8th data posedge; miso_buff_en stays 0.
- Read frame: address 0x15 with rw_bit = 1 → addr_we, then sr_we 3 cycles after the last address edge; miso_buff_en high for exactly 8 negedges, then DONE; back to IDLE when CS rises.
- CS abort: raise CS after 3 address posedges → IDLE next cycle, counter = 0, no strobes; a following full write frame completes normally.
- Coincident events: CS rises in the same cycle as the 8th data posedge → no dm_we, state IDLE.
- Async reset during READ_SHIFT → miso_buff_en falls without waiting for clk; state_o = 0.
- SPI_FSM_TIMEOUT_EN build with TIMEOUT_CYCLES = 16: stop SCLK mid-address → DONE after 16 cycles with no strobe; IDLE after CS rises.
